// File: rtl/z80_bus_responder_pkg.sv
// Shared definitions for the Z80 bus responder: FSM states, cycle-type codes, defaults.
package z80_bus_responder_pkg;

   // Responder FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   // Decoded CPU bus cycle type
   typedef enum logic [1:0] {
      CYC_NONE   = 2'd0,
      CYC_MEM    = 2'd1,
      CYC_IO     = 2'd2,
      CYC_INTACK = 2'd3
   } cycle_e;

   localparam logic [7:0]  IDLE_DATA_DEF = 8'hFF;
   localparam int unsigned TIMEOUT_DEF   = 255;

endpackage

// File: rtl/z80_cycle_decode.sv
// Classifies the CPU strobes into memory / I/O / INTACK cycles and edge-detects cycle starts.
module z80_cycle_decode
   import z80_bus_responder_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic mreq_n,
   input  logic iorq_n,
   input  logic rd_n,
   input  logic wr_n,
   input  logic m1_n,
   input  logic rfsh_n,
   output logic mem_cycle,
   output logic io_cycle,
   output logic intack,
   output logic start
);

   cycle_e cyc;
   logic   active;
   logic   active_q;

   // Strobe decode; refresh cycles and INTACK never count as a backend cycle
   always_comb begin
      cyc = CYC_NONE;
      if (!iorq_n && !m1_n) begin
         cyc = CYC_INTACK;
      end else if (!iorq_n && m1_n && (!rd_n || !wr_n)) begin
         cyc = CYC_IO;
      end else if (!mreq_n && rfsh_n && (!rd_n || !wr_n)) begin
         cyc = CYC_MEM;
      end
   end

   assign mem_cycle = (cyc == CYC_MEM);
   assign io_cycle  = (cyc == CYC_IO);
   assign intack    = (cyc == CYC_INTACK);
   assign active    = mem_cycle || io_cycle;
   assign start     = active && !active_q;

   // Previous-clk copy of the decoded condition for edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         active_q <= 1'b0;
      end else begin
         active_q <= active;
      end
   end

endmodule

// File: rtl/z80_bus_responder.sv
// Bridges Z80 memory/I/O bus cycles to a req/ack backend, stretching the CPU with WAIT.
module z80_bus_responder
   import z80_bus_responder_pkg::*;
#(
   parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
   parameter logic [7:0]  IDLE_DATA = IDLE_DATA_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mreq_n,
   input  logic        iorq_n,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic        m1_n,
   input  logic        rfsh_n,
   input  logic [15:0] a,
   input  logic [7:0]  cpu_dout,
   output logic [7:0]  cpu_di,
   output logic        wait_n,
   output logic        int_n,
   input  logic        irq,
   input  logic [7:0]  irq_vector,
   output logic        bus_req,
   output logic        bus_we,
   output logic        bus_io,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_wdata,
   input  logic        bus_ack,
   input  logic [7:0]  bus_rdata,
   output logic        err
);

   localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [7:0]       rd_q;
   logic             bus_req_q;
   logic             bus_we_q;
   logic             bus_io_q;
   logic [15:0]      bus_addr_q;
   logic [7:0]       bus_wdata_q;
   logic             err_q;
   logic             int_n_q;

   logic mem_cycle;
   logic io_cycle;
   logic intack;
   logic start;
   logic active;

   z80_cycle_decode u_decode (
      .clk       (clk),
      .reset     (reset),
      .mreq_n    (mreq_n),
      .iorq_n    (iorq_n),
      .rd_n      (rd_n),
      .wr_n      (wr_n),
      .m1_n      (m1_n),
      .rfsh_n    (rfsh_n),
      .mem_cycle (mem_cycle),
      .io_cycle  (io_cycle),
      .intack    (intack),
      .start     (start)
   );

   assign active = mem_cycle || io_cycle;

   // Request FSM: latch the CPU cycle, wait for ack or timeout, hold until strobes drop
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         rd_q        <= IDLE_DATA;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_io_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         err_q       <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q     <= ST_REQ;
                  bus_req_q   <= 1'b1;
                  bus_addr_q  <= a;
                  bus_we_q    <= !wr_n;
                  bus_io_q    <= !iorq_n;
                  bus_wdata_q <= cpu_dout;
                  cnt_q       <= '0;
               end
            end
            ST_REQ: begin
               if (!active) begin
                  // CPU abandoned the cycle: silent abort
                  state_q   <= ST_IDLE;
                  bus_req_q <= 1'b0;
               end else if (bus_ack) begin
                  // Ack takes priority over a coincident timeout
                  state_q   <= ST_HOLD;
                  bus_req_q <= 1'b0;
                  if (!bus_we_q) begin
                     rd_q <= bus_rdata;
                  end
               end else if (cnt_q == CNT_LAST) begin
                  state_q   <= ST_HOLD;
                  bus_req_q <= 1'b0;
                  rd_q      <= IDLE_DATA;
                  err_q     <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_HOLD: begin
               if (!active) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               bus_req_q <= 1'b0;
            end
         endcase
      end
   end

   // Interrupt line follows irq one clk later
   always_ff @(posedge clk) begin
      if (reset) begin
         int_n_q <= 1'b1;
      end else begin
         int_n_q <= !irq;
      end
   end

   // WAIT must assert in the same T-state as the strobes, so it is decoded combinationally
   always_comb begin
      wait_n = 1'b1;
      if (state_q == ST_REQ || (state_q == ST_IDLE && start)) begin
         wait_n = 1'b0;
      end
   end

   // CPU read data mux: INTACK vector, held backend data, otherwise idle pattern
   always_comb begin
      cpu_di = IDLE_DATA;
      if (intack) begin
         cpu_di = irq_vector;
      end else if (state_q == ST_HOLD && !rd_n) begin
         cpu_di = rd_q;
      end
   end

   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_io    = bus_io_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign err       = err_q;
   assign int_n     = int_n_q;

endmodule

// File: tb/tb_z80_bus_responder.sv
// Self-checking bench for z80_bus_responder: table of bus transactions plus corner-case sequences.
module tb_z80_bus_responder;

   localparam int unsigned TO = 8;
   localparam int NO_ACK = 1000;

   logic        clk = 1'b0;
   logic        reset;
   logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
   logic [15:0] a;
   logic [7:0]  cpu_dout;
   logic [7:0]  cpu_di;
   logic        wait_n, int_n;
   logic        irq;
   logic [7:0]  irq_vector;
   logic        bus_req, bus_we, bus_io;
   logic [15:0] bus_addr;
   logic [7:0]  bus_wdata;
   logic        bus_ack;
   logic [7:0]  bus_rdata;
   logic        err;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        io;
      logic        wr;
      logic [15:0] addr;
      logic [7:0]  wdata;
      int          ack_dly;
      logic [7:0]  rdata;
   } txn_t;

   typedef struct {
      logic [15:0] addr;
      logic        we;
      logic        io;
      logic [7:0]  wdata;
      logic [7:0]  cpu_di;
      int          waits;
      int          reqs;
      int          errs;
   } exp_t;

   txn_t txns[6];
   exp_t exp_q[$];

   z80_bus_responder #(.TIMEOUT(TO), .IDLE_DATA(8'hFF)) dut (
      .clk        (clk),
      .reset      (reset),
      .mreq_n     (mreq_n),
      .iorq_n     (iorq_n),
      .rd_n       (rd_n),
      .wr_n       (wr_n),
      .m1_n       (m1_n),
      .rfsh_n     (rfsh_n),
      .a          (a),
      .cpu_dout   (cpu_dout),
      .cpu_di     (cpu_di),
      .wait_n     (wait_n),
      .int_n      (int_n),
      .irq        (irq),
      .irq_vector (irq_vector),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_io     (bus_io),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_ack    (bus_ack),
      .bus_rdata  (bus_rdata),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic release_strobes();
      mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
      m1_n = 1'b1; rfsh_n = 1'b1;
   endtask

   // Drive one memory/I/O cycle; expected result is queued up front, compared when the cycle ends
   task automatic run_txn(input txn_t t, input int idx);
      exp_t e, got;
      int   k;
      bit   done, captured;
      bit   acked;

      acked    = (t.ack_dly < int'(TO));
      e.addr   = t.addr;
      e.we     = t.wr;
      e.io     = t.io;
      e.wdata  = t.wdata;
      e.waits  = acked ? t.ack_dly + 2 : int'(TO) + 1;
      e.reqs   = e.waits - 1;
      e.errs   = acked ? 0 : 1;
      e.cpu_di = (acked && !t.wr) ? t.rdata : 8'hFF;
      exp_q.push_back(e);

      got = '{addr: 16'h0, we: 1'b0, io: 1'b0, wdata: 8'h0, cpu_di: 8'h0,
              waits: 0, reqs: 0, errs: 0};
      next_cycle();
      mreq_n = t.io; iorq_n = !t.io; rd_n = t.wr; wr_n = !t.wr;
      a = t.addr; cpu_dout = t.wdata; bus_rdata = t.rdata; bus_ack = 1'b0;
      k = 0; done = 0; captured = 0;
      while (!done && k < 40) begin
         @(negedge clk);
         if (!wait_n) got.waits++;
         if (err) got.errs++;
         if (bus_req) begin
            got.reqs++;
            if (!captured) begin
               captured  = 1;
               got.addr  = bus_addr;
               got.we    = bus_we;
               got.io    = bus_io;
               got.wdata = bus_wdata;
            end
         end
         if (wait_n && k > 0) begin
            done = 1;
            got.cpu_di = cpu_di;
         end else begin
            next_cycle();
            k++;
            bus_ack = (k == t.ack_dly + 1);
         end
      end
      chk($sformatf("txn%0d_completes", idx), 32'(done), 32'd1);
      // Stay in HOLD one more clk: data must persist, err must not repeat
      next_cycle();
      bus_ack = 1'b0;
      @(negedge clk);
      if (err) got.errs++;
      chk($sformatf("txn%0d_hold_data", idx), 32'(cpu_di), 32'(e.cpu_di));
      // Drop strobes for exactly one clk; the next transaction reasserts right after
      next_cycle();
      release_strobes();
      @(negedge clk);
      chk($sformatf("txn%0d_idle_di", idx), 32'(cpu_di), 32'hFF);

      e = exp_q.pop_front();
      chk($sformatf("txn%0d_addr", idx),   32'(got.addr),   32'(e.addr));
      chk($sformatf("txn%0d_we", idx),     32'(got.we),     32'(e.we));
      chk($sformatf("txn%0d_io", idx),     32'(got.io),     32'(e.io));
      chk($sformatf("txn%0d_wdata", idx),  32'(got.wdata),  32'(e.wdata));
      chk($sformatf("txn%0d_cpu_di", idx), 32'(got.cpu_di), 32'(e.cpu_di));
      chk($sformatf("txn%0d_waits", idx),  32'(got.waits),  32'(e.waits));
      chk($sformatf("txn%0d_reqs", idx),   32'(got.reqs),   32'(e.reqs));
      chk($sformatf("txn%0d_errs", idx),   32'(got.errs),   32'(e.errs));
   endtask

   initial begin
      txns[0] = '{io: 1'b0, wr: 1'b0, addr: 16'h4000, wdata: 8'h00, ack_dly: 2,      rdata: 8'hA5};
      txns[1] = '{io: 1'b1, wr: 1'b1, addr: 16'h00FE, wdata: 8'h07, ack_dly: 0,      rdata: 8'h00};
      txns[2] = '{io: 1'b0, wr: 1'b0, addr: 16'h1234, wdata: 8'h00, ack_dly: NO_ACK, rdata: 8'h66};
      txns[3] = '{io: 1'b0, wr: 1'b1, addr: 16'h8000, wdata: 8'h3C, ack_dly: 7,      rdata: 8'h00};
      txns[4] = '{io: 1'b1, wr: 1'b0, addr: 16'h0042, wdata: 8'h00, ack_dly: 1,      rdata: 8'h5A};
      txns[5] = '{io: 1'b0, wr: 1'b0, addr: 16'hFFFF, wdata: 8'h00, ack_dly: 0,      rdata: 8'h00};

      reset = 1'b1;
      release_strobes();
      a = 16'h0; cpu_dout = 8'h0; irq = 1'b0; irq_vector = 8'h00;
      bus_ack = 1'b0; bus_rdata = 8'h00;

      // Reset state
      repeat (3) next_cycle();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_wait_n",    32'(wait_n),    32'd1);
      chk("rst_bus_req",   32'(bus_req),   32'd0);
      chk("rst_int_n",     32'(int_n),     32'd1);
      chk("rst_err",       32'(err),       32'd0);
      chk("rst_cpu_di",    32'(cpu_di),    32'hFF);
      chk("rst_bus_addr",  32'(bus_addr),  32'h0);
      chk("rst_bus_we",    32'(bus_we),    32'd0);
      chk("rst_bus_io",    32'(bus_io),    32'd0);
      chk("rst_bus_wdata", 32'(bus_wdata), 32'h0);

      // Transaction table, back-to-back with a one-clk strobe gap
      for (int i = 0; i < 6; i++) run_txn(txns[i], i);

      // Interrupt request and INTACK
      next_cycle();
      irq = 1'b1; irq_vector = 8'hFE;
      @(negedge clk);
      chk("int_n_not_yet", 32'(int_n), 32'd1);
      next_cycle();
      @(negedge clk);
      chk("int_n_asserted", 32'(int_n), 32'd0);
      next_cycle();
      iorq_n = 1'b0; m1_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("intack_di%0d", i),   32'(cpu_di),  32'hFE);
         chk($sformatf("intack_wait%0d", i), 32'(wait_n),  32'd1);
         chk($sformatf("intack_req%0d", i),  32'(bus_req), 32'd0);
         next_cycle();
      end
      release_strobes();
      irq = 1'b0;
      @(negedge clk);
      chk("post_intack_di", 32'(cpu_di), 32'hFF);

      // Refresh cycle with rd_n low must still be ignored
      next_cycle();
      mreq_n = 1'b0; rfsh_n = 1'b0; rd_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("rfsh_req%0d", i),  32'(bus_req), 32'd0);
         chk($sformatf("rfsh_wait%0d", i), 32'(wait_n),  32'd1);
         next_cycle();
      end
      release_strobes();

      // Ack while idle is ignored
      bus_ack = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk($sformatf("idle_ack_req%0d", i),  32'(bus_req), 32'd0);
         chk($sformatf("idle_ack_wait%0d", i), 32'(wait_n),  32'd1);
         next_cycle();
      end
      bus_ack = 1'b0;

      // CPU drops strobes while the request is pending
      next_cycle();
      mreq_n = 1'b0; rd_n = 1'b0; a = 16'h2222;
      @(negedge clk);
      chk("abort_start_wait", 32'(wait_n), 32'd0);
      next_cycle();
      @(negedge clk);
      chk("abort_req_on", 32'(bus_req), 32'd1);
      next_cycle();
      release_strobes();
      @(negedge clk);
      chk("abort_still_req", 32'(bus_req), 32'd1);
      next_cycle();
      @(negedge clk);
      chk("abort_req_off", 32'(bus_req), 32'd0);
      chk("abort_wait_n",  32'(wait_n),  32'd1);
      chk("abort_err",     32'(err),     32'd0);
      for (int i = 0; i < int'(TO); i++) begin
         next_cycle();
         @(negedge clk);
         if (err) chk("abort_late_err", 32'(err), 32'd0);
      end

      // Reset two clks into REQ
      next_cycle();
      mreq_n = 1'b0; rd_n = 1'b0; a = 16'h3333;
      next_cycle();
      @(negedge clk);
      chk("rstreq_req_on", 32'(bus_req), 32'd1);
      next_cycle();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      release_strobes();
      @(negedge clk);
      chk("rstreq_req_off", 32'(bus_req), 32'd0);
      chk("rstreq_wait_n",  32'(wait_n),  32'd1);
      chk("rstreq_err",     32'(err),     32'd0);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
